// File: rtl/ipu_pkg.sv
// Shared IPU capture definitions: capture FSM states and default widths.
package ipu_pkg;

  localparam int DIV_W_DEF = 4;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ARM,
    IDLE,
    PASS,
    SKIP
  } state_t;

endpackage

// File: rtl/fval_edge_detect.sv
// Frame-valid edge detector with optional 2-flop input synchroniser.
// Define FRAME_DECIMATOR_SYNC_EN to synchronise FVAL/LVAL/DVAL first.
module fval_edge_detect (
  input  logic iCLK,
  input  logic iRST,
  input  logic iFVAL,
  input  logic iLVAL,
  input  logic iDVAL,
  output logic fval,
  output logic lval,
  output logic dval,
  output logic sof,
  output logic eof
);

  logic fval_q;

`ifdef FRAME_DECIMATOR_SYNC_EN
  logic [2:0] sync1, sync2;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {iFVAL, iLVAL, iDVAL};
      sync2 <= sync1;
    end
  end

  assign {fval, lval, dval} = sync2;
`else
  assign fval = iFVAL;
  assign lval = iLVAL;
  assign dval = iDVAL;
`endif

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) fval_q <= 1'b0;
    else      fval_q <= fval;
  end

  assign sof = fval & ~fval_q;
  assign eof = ~fval & fval_q;

endmodule

// File: rtl/frame_decimator.sv
// Frame-rate decimator: passes one sensor frame in every iDIV.
// Define FRAME_DECIMATOR_SYNC_EN for synchronised sensor strobes.
module frame_decimator
  import ipu_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iFVAL,
  input  logic             iLVAL,
  input  logic             iDVAL,
  input  logic             iEnable,
  input  logic [DIV_W-1:0] iDIV,
  output logic             oFVAL,
  output logic             oLVAL,
  output logic             oDVAL,
  output logic             oFrame_En,
  output logic             oSOF,
  output logic             oEOF,
  output logic [CNT_W-1:0] oRx_Cnt,
  output logic [CNT_W-1:0] oPass_Cnt
);

  logic fval, lval, dval, sof, eof;

  fval_edge_detect u_edge (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iFVAL (iFVAL),
    .iLVAL (iLVAL),
    .iDVAL (iDVAL),
    .fval  (fval),
    .lval  (lval),
    .dval  (dval),
    .sof   (sof),
    .eof   (eof)
  );

  state_t           state, state_nxt;
  logic [DIV_W-1:0] phase, phase_nxt, div_q;
  logic [DIV_W:0]   ph_inc;
  logic             div_chg, pass_ok, take, gate;

  always_comb begin
    div_chg   = (iDIV != div_q);
    pass_ok   = iEnable && (iDIV != '0) && ((phase == '0) || div_chg);
    ph_inc    = div_chg ? (DIV_W+1)'(1) : {1'b0, phase} + 1'b1;
    phase_nxt = phase;
    // >= rather than == keeps phase sane after a divisor shrink while disabled
    if (iEnable && (iDIV != '0))
      phase_nxt = (ph_inc >= {1'b0, iDIV}) ? '0 : ph_inc[DIV_W-1:0];
    take      = (state == IDLE) && sof;
    gate      = (state == PASS) || (take && pass_ok);
    state_nxt = state;
    unique case (state)
      ARM:  if (!fval) state_nxt = IDLE;
      IDLE: if (sof)   state_nxt = pass_ok ? PASS : SKIP;
      PASS: if (eof)   state_nxt = IDLE;
      SKIP: if (eof)   state_nxt = IDLE;
      default:         state_nxt = ARM;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= ARM;
    else      state <= state_nxt;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      phase     <= '0;
      div_q     <= '0;
      oRx_Cnt   <= '0;
      oPass_Cnt <= '0;
      oFVAL     <= 1'b0;
      oLVAL     <= 1'b0;
      oDVAL     <= 1'b0;
      oSOF      <= 1'b0;
      oEOF      <= 1'b0;
    end else begin
      if (take) begin
        oRx_Cnt <= oRx_Cnt + 1'b1;
        div_q   <= iDIV;
        phase   <= phase_nxt;
      end
      if ((state == PASS) && eof)
        oPass_Cnt <= oPass_Cnt + 1'b1;
      oFVAL <= fval & gate;
      oLVAL <= lval & gate;
      oDVAL <= dval & gate;
      oSOF  <= take & pass_ok;
      oEOF  <= (state == PASS) & eof;
    end
  end

  // PASS spans exactly the cycles where the gated oFVAL is high
  assign oFrame_En = (state == PASS);

endmodule

// File: tb/tb_frame_decimator.sv
// Directed self-checking bench for frame_decimator.
module tb_frame_decimator;

`ifdef FRAME_DECIMATOR_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iFVAL = 1'b0, iLVAL = 1'b0, iDVAL = 1'b0;
  logic        iEnable = 1'b1;
  logic [3:0]  iDIV = 4'd1;
  logic        oFVAL, oLVAL, oDVAL, oFrame_En, oSOF, oEOF;
  logic [15:0] oRx_Cnt, oPass_Cnt;

  int vec = 0;
  int bad = 0;
  int sof_n = 0, eof_n = 0, fv_n = 0, fe_n = 0;

  frame_decimator dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iFVAL     (iFVAL),
    .iLVAL     (iLVAL),
    .iDVAL     (iDVAL),
    .iEnable   (iEnable),
    .iDIV      (iDIV),
    .oFVAL     (oFVAL),
    .oLVAL     (oLVAL),
    .oDVAL     (oDVAL),
    .oFrame_En (oFrame_En),
    .oSOF      (oSOF),
    .oEOF      (oEOF),
    .oRx_Cnt   (oRx_Cnt),
    .oPass_Cnt (oPass_Cnt)
  );

  always #5 iCLK = ~iCLK;

  always @(negedge iCLK) begin
    if (oSOF)      sof_n++;
    if (oEOF)      eof_n++;
    if (oFVAL)     fv_n++;
    if (oFrame_En) fe_n++;
  end

  task automatic step(input logic f, input logic l, input logic d);
    @(posedge iCLK);
    #1;
    iFVAL = f;
    iLVAL = l;
    iDVAL = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    iRST  = 1'b1;
    iFVAL = 1'b0;
    iLVAL = 1'b0;
    iDVAL = 1'b0;
    repeat (2) @(posedge iCLK);
    #1 iRST = 1'b0;
    idle(2);
  endtask

  // len cycles of FVAL; at cycle chg_at the divisor/enable are changed
  task automatic send_frame(input int len, input int chg_at,
                            input logic [3:0] nd, input logic ne);
    logic l;
    for (int i = 0; i < len; i++) begin
      l = (i % 4) != 3;
      step(1'b1, l, l & i[0]);
      if (i == chg_at) begin
        iDIV    = nd;
        iEnable = ne;
      end
    end
    idle(6);
  endtask

  task automatic frame_chk(input string nm, input logic exp);
    logic [15:0] p0;
    logic got;
    p0 = oPass_Cnt;
    send_frame(6, -1, iDIV, iEnable);
    got = (oPass_Cnt != p0);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s passed=%0b expected=%0b", nm, got, exp);
    end
  endtask

  task automatic test_reset();
    iRST = 1'b1; iFVAL = 1'b1; iDIV = 4'd1; iEnable = 1'b1;
    @(negedge iCLK);
    vec++;
    if ({oFVAL, oLVAL, oDVAL, oSOF, oEOF, oFrame_En} !== 6'b0 ||
        oRx_Cnt !== 16'd0 || oPass_Cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_outputs fval=%b rx=%0d pass=%0d expected 0",
               oFVAL, oRx_Cnt, oPass_Cnt);
    end
    @(posedge iCLK);
    #1 iRST = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b1);
      @(negedge iCLK);
      vec++;
      if (oFVAL !== 1'b0 || oFrame_En !== 1'b0) begin
        bad++;
        $display("FAIL arm_partial cyc=%0d oFVAL=%b en=%b expected 0",
                 i, oFVAL, oFrame_En);
      end
    end
    idle(4);
    vec++;
    if (oRx_Cnt !== 16'd0) begin
      bad++;
      $display("FAIL arm_rx rx=%0d expected 0", oRx_Cnt);
    end
    send_frame(8, -1, 4'd1, 1'b1);
    vec++;
    if (oRx_Cnt !== 16'd1 || oPass_Cnt !== 16'd1) begin
      bad++;
      $display("FAIL first_frame rx=%0d pass=%0d expected 1/1",
               oRx_Cnt, oPass_Cnt);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    @(negedge iCLK);
    #2 iRST = 1'b1;
    #1;
    vec++;
    if (oFVAL !== 1'b0 || oFrame_En !== 1'b0 || oRx_Cnt !== 16'd0) begin
      bad++;
      $display("FAIL async_reset fval=%b en=%b rx=%0d expected 0/0/0",
               oFVAL, oFrame_En, oRx_Cnt);
    end
    step(1'b1, 1'b1, 1'b0);
    iRST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b1);
      @(negedge iCLK);
      vec++;
      if (oFVAL !== 1'b0) begin
        bad++;
        $display("FAIL rearm cyc=%0d oFVAL=%b expected 0", i, oFVAL);
      end
    end
    idle(4);
  endtask

  task automatic test_div5();
    int s0, e0;
    do_reset();
    iDIV = 4'd5; iEnable = 1'b1;
    s0 = sof_n; e0 = eof_n;
    for (int f = 1; f <= 12; f++)
      frame_chk($sformatf("div5_f%0d", f), f == 1 || f == 6 || f == 11);
    vec++;
    if (oRx_Cnt !== 16'd12 || oPass_Cnt !== 16'd3) begin
      bad++;
      $display("FAIL div5_cnt rx=%0d pass=%0d expected 12/3",
               oRx_Cnt, oPass_Cnt);
    end
    vec++;
    if (sof_n - s0 !== 3 || eof_n - e0 !== 3) begin
      bad++;
      $display("FAIL div5_pulses sof=%0d eof=%0d expected 3/3",
               sof_n - s0, eof_n - e0);
    end
  endtask

  task automatic test_div_change();
    int f0;
    do_reset();
    iDIV = 4'd5; iEnable = 1'b1;
    frame_chk("chg_f1", 1'b1);
    frame_chk("chg_f2", 1'b0);
    send_frame(6, 2, 4'd2, 1'b1);
    vec++;
    if (oPass_Cnt !== 16'd1) begin
      bad++;
      $display("FAIL chg_f3 pass=%0d expected 1", oPass_Cnt);
    end
    f0 = fv_n;
    send_frame(6, 2, 4'd2, 1'b0);
    iEnable = 1'b1;
    vec++;
    if (fv_n - f0 !== 6 || oPass_Cnt !== 16'd2) begin
      bad++;
      $display("FAIL chg_f4 fval_cycles=%0d pass=%0d expected 6/2",
               fv_n - f0, oPass_Cnt);
    end
    frame_chk("chg_f5", 1'b0);
    frame_chk("chg_f6", 1'b1);
  endtask

  task automatic test_enable();
    int f0;
    do_reset();
    iDIV = 4'd3; iEnable = 1'b1;
    frame_chk("en_f1", 1'b1);
    frame_chk("en_f2", 1'b0);
    iEnable = 1'b0;
    f0 = fv_n;
    for (int f = 3; f <= 6; f++) frame_chk($sformatf("en_f%0d", f), 1'b0);
    vec++;
    if (fv_n != f0 || oRx_Cnt !== 16'd6 || oPass_Cnt !== 16'd1) begin
      bad++;
      $display("FAIL en_off fval_cycles=%0d rx=%0d pass=%0d expected 0/6/1",
               fv_n - f0, oRx_Cnt, oPass_Cnt);
    end
    iEnable = 1'b1;
    frame_chk("en_f7_held_phase", 1'b0);
    frame_chk("en_f8", 1'b1);
  endtask

  task automatic test_div0();
    do_reset();
    iDIV = 4'd0; iEnable = 1'b1;
    for (int f = 1; f <= 3; f++) frame_chk($sformatf("div0_f%0d", f), 1'b0);
    vec++;
    if (oRx_Cnt !== 16'd3 || oPass_Cnt !== 16'd0) begin
      bad++;
      $display("FAIL div0_cnt rx=%0d pass=%0d expected 3/0",
               oRx_Cnt, oPass_Cnt);
    end
    iDIV = 4'd3;
    frame_chk("div0_to3", 1'b1);
  endtask

  task automatic test_single();
    int s0, e0, f0, n0;
    do_reset();
    iDIV = 4'd1; iEnable = 1'b1;
    s0 = sof_n; e0 = eof_n; f0 = fv_n; n0 = fe_n;
    step(1'b1, 1'b1, 1'b1);
    idle(6);
    vec++;
    if (fv_n - f0 !== 1 || fe_n - n0 !== 1 || sof_n - s0 !== 1 ||
        eof_n - e0 !== 1 || oPass_Cnt !== 16'd1) begin
      bad++;
      $display("FAIL single fval=%0d en=%0d sof=%0d eof=%0d pass=%0d expected 1/1/1/1/1",
               fv_n - f0, fe_n - n0, sof_n - s0, eof_n - e0, oPass_Cnt);
    end
  endtask

  task automatic test_gating();
    logic [2:0] pat [32];
    logic [2:0] exp;
    logic [3:0] divs [3];
    logic       pass [3];
    divs[0] = 4'd1; divs[1] = 4'd2; divs[2] = 4'd2;
    pass[0] = 1'b1; pass[1] = 1'b1; pass[2] = 1'b0;
    for (int c = 0; c < 32; c++) begin
      pat[c][2] = (c >= 2) && (c < 22);
      pat[c][1] = pat[c][2] && ((c % 6) < 4);
      pat[c][0] = pat[c][1] && ((c % 2) == 1);
    end
    do_reset();
    iEnable = 1'b1;
    for (int r = 0; r < 3; r++) begin
      iDIV = divs[r];
      for (int c = 0; c < 32; c++) begin
        step(pat[c][2], pat[c][1], pat[c][0]);
        @(negedge iCLK);
        exp = (c >= LAT && pass[r]) ? pat[c-LAT] : 3'b000;
        vec++;
        if ({oFVAL, oLVAL, oDVAL} !== exp) begin
          bad++;
          $display("FAIL gate_r%0d_c%0d f/l/d=%b expected %b",
                   r, c, {oFVAL, oLVAL, oDVAL}, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_div5();
    test_div_change();
    test_enable();
    test_div0();
    test_single();
    test_gating();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

// File: doc/frame_decimator.md
Name: frame_decimator

Overview:
- Parametrised frame-rate decimator for the camera-to-IPU capture path.
- Detects frame starts on the sensor frame-valid strobe and passes one frame in every N, where N is programmable at run time.
- Passed frames go downstream as gated, registered frame/line/data-valid strobes; skipped frames are fully suppressed.
- Provides frame-boundary pulses and frame statistics counters for the IPU control logic.

Parameters:
- DIV_W, 4, width of divisor input iDIV (max divisor 2^DIV_W-1).
- CNT_W, 16, width of received/passed frame counters (wrap modulo 2^CNT_W).

Ports:
- iCLK  in  1  pixel clock.
- iRST  in  1  reset, asynchronous, active-high.
- iFVAL  in  1  sensor frame valid.
- iLVAL  in  1  sensor line valid.
- iDVAL  in  1  sensor data valid.
- iEnable  in  1  capture enable; 0 = skip all frames.
- iDIV  in  DIV_W  decimation factor N; pass 1 of every N frames.
- oFVAL  out  1  gated frame valid.
- oLVAL  out  1  gated line valid.
- oDVAL  out  1  gated data valid.
- oFrame_En  out  1  high for the whole duration of a passed frame.
- oSOF  out  1  one-cycle pulse at start of a passed frame.
- oEOF  out  1  one-cycle pulse at end of a passed frame.
- oRx_Cnt  out  CNT_W  frames received.
- oPass_Cnt  out  CNT_W  frames passed.

Behaviour:
- Reset: all outputs are 0; state is ARM; phase = 0; div_q = 0; fval_q = 0.
- fval_q is a register holding iFVAL from the previous cycle.
  - SOF edge = iFVAL & ~fval_q.
  - EOF edge = ~iFVAL & fval_q.
- FSM:
  - ARM: wait for iFVAL = 0. This prevents capturing a partial frame after reset. Go to IDLE when iFVAL = 0.
  - IDLE: on SOF edge, increment oRx_Cnt, then evaluate the pass decision:
    - Pass if iEnable = 1, iDIV != 0, and (phase = 0 or iDIV != div_q).
    - Then div_q <= iDIV.
    - Next phase = 1 if the frame passed by divisor change, otherwise phase+1; either way wraps to 0 when the value reaches iDIV.
    - Go to PASS if passed, else SKIP.
  - PASS: oFrame_En = 1. On EOF edge, increment oPass_Cnt and go to IDLE.
  - SKIP: go to IDLE on EOF edge.
- iDIV = 1 passes every frame. iDIV = 0 or iEnable = 0 passes none; phase holds and oRx_Cnt still counts.
- Gating:
  - oFVAL/oLVAL/oDVAL are registered copies of iFVAL/iLVAL/iDVAL, ANDed with the pass decision.
  - Latency is 1 cycle; oFVAL rises the cycle after iFVAL.
  - oSOF is coincident with the first cycle of oFVAL = 1. oEOF is coincident with the first cycle of oFVAL = 0 after a passed frame.
- iEnable and iDIV are sampled only on the SOF edge. Changes mid-frame never truncate or extend a frame.
- Single-cycle FVAL high (SOF then EOF on the next cycle): handled normally, giving a one-cycle oFVAL/oFrame_En.
- Counters wrap silently. oPass_Cnt never exceeds oRx_Cnt modulo wrap.
- Asynchronous reset mid-frame clears outputs immediately and re-enters ARM.

Optional Feature:
- Macro: FRAME_DECIMATOR_SYNC_EN.
- Defined:
  - iFVAL, iLVAL and iDVAL each pass through a 2-flop synchroniser (reset 0) before all logic.
  - Total input-to-output latency is 3 cycles; all decisions use the synchronised signals.
- Undefined:
  - No synchroniser; latency is 1 cycle. Inputs must be synchronous to iCLK.

Decomposition:
- Shared package ipu_pkg holds:
  - the state enum (ARM, IDLE, PASS, SKIP);
  - default DIV_W/CNT_W constants.
- One natural sub-module: fval_edge_detect, containing the optional synchroniser, the previous-value register and the SOF/EOF edge outputs. It is reusable by other IPU capture blocks.

Test Plan:
- Reset with iFVAL = 1 mid-frame, iDIV = 1 → no output until iFVAL falls. The next full frame passes; oRx_Cnt = 1, oPass_Cnt = 1 after its EOF.
- iDIV = 5, 12 frames → frames 1, 6, 11 pass; oRx_Cnt = 12, oPass_Cnt = 3; oSOF/oEOF each pulse 3 times.
- iDIV changed 5→2 while frame 3 is active → frame 3 completes unchanged. Frame 4 passes (divisor change), then frame 6 passes.
- iEnable = 0 for 4 frames → oFVAL stays 0 and oPass_Cnt is unchanged; oRx_Cnt += 4. Phase is unchanged, so the frame that re-enables capture follows the held phase.
- iDIV = 0 → no frame passes. Set iDIV = 3 → the next frame passes immediately.
- oLVAL/oDVAL gating on a passed frame → each equals its input delayed by 1 cycle (3 cycles with FRAME_DECIMATOR_SYNC_EN). On a skipped frame → constant 0.
